pipe_stage_reg: RTL and testbench

- Generic, parametrised pipeline-stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data payload, with these behaviours:
  - valid/ready handshake for back-pressure;
  - synchronous flush for bubble insertion;
  - control-field gating, so bubbles never assert write or read enables;
  - optional two-entry skid buffer, which removes the combinational ready path.
- Saturating stall and flush counters feed the core performance monitor.

---
 rtl/core_pipe_pkg.sv | 30 +++
 rtl/sat_counter.sv | 33 +++
 rtl/pipe_stage_reg.sv | 189 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_pipe_pkg                                                            |
// | Shared types and constants for the generic pipeline-stage register.      |
// |   ex_mem_ctrl_t    : EX/MEM control-field layout                         |
// |   CTRL_W_EX_MEM    : control width of the EX/MEM instance                |
// |   DATA_W_EX_MEM    : payload width (alu_result + rs2_data + rd_addr)     |
// |   skid_state_t     : EMPTY / ONE / FULL occupancy encodings              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package core_pipe_pkg;

   typedef struct packed {
      logic reg_write_en;
      logic mem_to_reg;
      logic mem_read;
      logic mem_write;
   } ex_mem_ctrl_t;

   localparam int CTRL_W_EX_MEM = 4;
   localparam int DATA_W_EX_MEM = 69;

   // Occupancy of the main/skid register pair.
   typedef logic [1:0] skid_state_t;
   localparam skid_state_t c_skid_empty = 2'd0;  // main invalid
   localparam skid_state_t c_skid_one   = 2'd1;  // main valid, skid empty
   localparam skid_state_t c_skid_full  = 2'd2;  // main and skid valid

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_counter                                                              |
// | Up-counter that sticks at its all-ones value instead of wrapping.        |
// |   clk   : clock                                                          |
// |   rst   : asynchronous active-high reset, clears the count               |
// |   inc   : count one event this cycle                                     |
// |   count : current value                                                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_reg                                                           |
// | Parametrised pipeline-stage register with valid/ready back-pressure,     |
// | synchronous flush, control-field gating and optional skid buffer.        |
// |   clk, rst             : clock, asynchronous active-high reset           |
// |   flush                : kill held and incoming beats                    |
// |   in_valid/in_ready    : upstream handshake                              |
// |   in_ctrl/in_data      : upstream control bits and payload               |
// |   out_valid/out_ready  : downstream handshake                            |
// |   out_ctrl/out_data    : control (zero when invalid) and payload         |
// |   stall_cnt/flush_cnt  : saturating performance counters                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module pipe_stage_reg
   import core_pipe_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_EX_MEM,
   parameter int DATA_W = DATA_W_EX_MEM,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic              w_main_valid;
   logic [CTRL_W-1:0] w_main_ctrl;
   logic [DATA_W-1:0] w_main_data;
   logic              w_in_ready;
   logic              w_in_xfer;
   logic              w_out_xfer;
   logic              w_discard;

   assign w_in_xfer  = in_valid && w_in_ready;
   assign w_out_xfer = w_main_valid && out_ready;

   generate
      if (SKID == 0) begin : g_single
         logic              r_valid;
         logic [CTRL_W-1:0] r_ctrl;
         logic [DATA_W-1:0] r_data;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_valid <= 1'b0;
               r_ctrl  <= '0;
               r_data  <= '0;
            end else if (flush) begin
               r_valid <= 1'b0;
            end else if (w_in_xfer) begin
               r_valid <= 1'b1;
               r_ctrl  <= in_ctrl;
               r_data  <= in_data;
            end else if (w_out_xfer) begin
               r_valid <= 1'b0;
            end
         end

         assign w_in_ready   = out_ready || !r_valid;
         assign w_main_valid = r_valid;
         assign w_main_ctrl  = r_ctrl;
         assign w_main_data  = r_data;
         // A held beat leaving in the flush cycle is not a discard.
         assign w_discard    = (r_valid && !out_ready) || w_in_xfer;
      end else begin : g_skid
         skid_state_t       r_state;
         skid_state_t       w_next_state;
         logic              r_in_ready;
         logic [CTRL_W-1:0] r_main_ctrl;
         logic [DATA_W-1:0] r_main_data;
         logic [CTRL_W-1:0] r_skid_ctrl;
         logic [DATA_W-1:0] r_skid_data;
         logic              w_ld_main_in;
         logic              w_ld_main_skid;
         logic              w_ld_skid;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_state    <= c_skid_empty;
               r_in_ready <= 1'b1;
            end else begin
               r_state    <= w_next_state;
               // Registered ready breaks the out_ready -> in_ready path.
               r_in_ready <= (w_next_state != c_skid_full);
            end
         end

         always_comb begin
            w_next_state   = r_state;
            w_ld_main_in   = 1'b0;
            w_ld_main_skid = 1'b0;
            w_ld_skid      = 1'b0;
            if (flush) begin
               w_next_state = c_skid_empty;
            end else begin
               case (r_state)
                  c_skid_empty: begin
                     if (w_in_xfer) begin
                        w_next_state = c_skid_one;
                        w_ld_main_in = 1'b1;
                     end
                  end
                  c_skid_one: begin
                     if (w_out_xfer && w_in_xfer) begin
                        w_ld_main_in = 1'b1;
                     end else if (w_out_xfer) begin
                        w_next_state = c_skid_empty;
                     end else if (w_in_xfer) begin
                        w_next_state = c_skid_full;
                        w_ld_skid    = 1'b1;
                     end
                  end
                  c_skid_full: begin
                     // in_ready is low here, so the skid beat is the only
                     // candidate for main and order is preserved.
                     if (w_out_xfer) begin
                        w_next_state   = c_skid_one;
                        w_ld_main_skid = 1'b1;
                     end
                  end
                  default: w_next_state = c_skid_empty;
               endcase
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_main_ctrl <= '0;
               r_main_data <= '0;
               r_skid_ctrl <= '0;
               r_skid_data <= '0;
            end else begin
               if (w_ld_main_in) begin
                  r_main_ctrl <= in_ctrl;
                  r_main_data <= in_data;
               end else if (w_ld_main_skid) begin
                  r_main_ctrl <= r_skid_ctrl;
                  r_main_data <= r_skid_data;
               end
               if (w_ld_skid) begin
                  r_skid_ctrl <= in_ctrl;
                  r_skid_data <= in_data;
               end
            end
         end

         assign w_in_ready   = r_in_ready;
         assign w_main_valid = (r_state != c_skid_empty);
         assign w_main_ctrl  = r_main_ctrl;
         assign w_main_data  = r_main_data;
         assign w_discard    = (w_main_valid && !out_ready) ||
                               (r_state == c_skid_full) || w_in_xfer;
      end
   endgenerate

   assign in_ready  = w_in_ready;
   assign out_valid = w_main_valid;
   // Bubbles must never raise write/read enables downstream.
   assign out_ctrl  = w_main_ctrl & {CTRL_W{w_main_valid}};
   assign out_data  = w_main_data;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_main_valid && !out_ready && !flush),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush && w_discard),
      .count (flush_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_stage_reg                                                        |
// | Three instances (SKID=1/CNT_W=16, SKID=0/CNT_W=16, SKID=1/CNT_W=4) share |
// | one stimulus stream; each has a queue-based occupancy model.             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_reg;

   localparam int NI = 3;

   typedef struct packed {
      logic [3:0]  c;
      logic [68:0] d;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [3:0]  in_ctrl = '0;
   logic [68:0] in_data = '0;

   logic        ov0, ov1, ov2, ir0, ir1, ir2;
   logic [3:0]  oc0, oc1, oc2;
   logic [68:0] od0, od1, od2;
   logic [15:0] sc0, sc1, fc0, fc1;
   logic [3:0]  sc2, fc2;

   logic        ov [NI];
   logic        ir [NI];
   logic [3:0]  oc [NI];
   logic [68:0] od [NI];
   logic [15:0] sc [NI];
   logic [15:0] fc [NI];

   beat_t mq [NI][$];
   int    m_stall [NI];
   int    m_flush [NI];
   bit    m_ir [NI];
   bit    popped [NI];
   bit    is_skid [NI] = '{1'b1, 1'b0, 1'b1};
   int    cmax [NI] = '{65535, 65535, 15};

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.CTRL_W(4), .DATA_W(69), .SKID(1), .CNT_W(16)) dut_s1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
      .out_ctrl(oc0), .out_data(od0), .stall_cnt(sc0), .flush_cnt(fc0));

   pipe_stage_reg #(.CTRL_W(4), .DATA_W(69), .SKID(0), .CNT_W(16)) dut_s0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
      .out_ctrl(oc1), .out_data(od1), .stall_cnt(sc1), .flush_cnt(fc1));

   pipe_stage_reg #(.CTRL_W(4), .DATA_W(69), .SKID(1), .CNT_W(4)) dut_c4 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov2), .out_ready(out_ready),
      .out_ctrl(oc2), .out_data(od2), .stall_cnt(sc2), .flush_cnt(fc2));

   always_comb begin
      ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
      ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
      oc[0] = oc0; oc[1] = oc1; oc[2] = oc2;
      od[0] = od0; od[1] = od1; od[2] = od2;
      sc[0] = sc0; sc[1] = sc1; sc[2] = {12'd0, sc2};
      fc[0] = fc0; fc[1] = fc1; fc[2] = {12'd0, fc2};
   end

   task automatic chk(input string name, input int k, input logic [68:0] act,
                      input logic [68:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst=%0d t=%0t got=%h expected=%h", name, k, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         mq[k].delete();
         m_stall[k] = 0;
         m_flush[k] = 0;
         m_ir[k]    = 1'b1;
         popped[k]  = 1'b0;
      end
   endtask

   // Monitor: compares presented state and pops each beat as it leaves.
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         bit mv;
         bit exp_ir;
         mv = (mq[k].size() > 0);
         exp_ir = is_skid[k] ? m_ir[k] : (out_ready || !mv);
         chk("out_valid", k, 69'(ov[k]), 69'(mv));
         if (mv) begin
            chk("out_data", k, od[k], mq[k][0].d);
            chk("out_ctrl", k, 69'(oc[k]), 69'(mq[k][0].c));
         end else begin
            chk("ctrl_gated", k, 69'(oc[k]), 69'd0);
         end
         chk("in_ready", k, 69'(ir[k]), 69'(exp_ir));
         chk("stall_cnt", k, 69'(sc[k]), 69'(m_stall[k]));
         chk("flush_cnt", k, 69'(fc[k]), 69'(m_flush[k]));
         if (rst) chk("rst_data", k, od[k], 69'd0);
         if (!rst && mv && out_ready) begin
            void'(mq[k].pop_front());
            popped[k] = 1'b1;
         end
      end
   end

   // Reference model: occupancy queue advanced at each clock edge.
   always @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < NI; k++) begin
            int    occ;
            bit    inx;
            beat_t b;
            occ = mq[k].size() + (popped[k] ? 1 : 0);
            inx = in_valid && (is_skid[k] ? m_ir[k] : (out_ready || occ == 0));
            if (occ > 0 && !out_ready && !flush && m_stall[k] < cmax[k])
               m_stall[k]++;
            if (flush) begin
               if ((mq[k].size() > 0 || inx) && m_flush[k] < cmax[k])
                  m_flush[k]++;
               mq[k].delete();
            end else if (inx) begin
               b.c = in_ctrl;
               b.d = in_data;
               mq[k].push_back(b);
            end
            m_ir[k]   = flush ? 1'b1 : (mq[k].size() < 2);
            popped[k] = 1'b0;
         end
      end
   end

   task automatic step(input logic v, input logic f, input logic r,
                       input logic [3:0] c, input logic [68:0] d);
      @(posedge clk);
      #1;
      in_valid  = v;
      flush     = f;
      out_ready = r;
      in_ctrl   = c;
      in_data   = d;
   endtask

   function automatic logic [68:0] rnd_data();
      logic [95:0] w;
      w = {$urandom, $urandom, $urandom};
      return w[68:0];
   endfunction

   initial begin
      model_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Streaming at full rate.
      step(1, 0, 1, 4'h3, 69'h11);
      step(1, 0, 1, 4'h5, 69'h22);
      repeat (3) step(0, 0, 1, 4'h0, 69'h0);

      // Back-pressure: A, B accepted, C held upstream, then drain.
      step(1, 0, 0, 4'h1, 69'hA);
      step(1, 0, 0, 4'h2, 69'hB);
      repeat (4) step(1, 0, 0, 4'h4, 69'hC);
      step(1, 0, 1, 4'h4, 69'hC);
      repeat (5) step(0, 0, 1, 4'h0, 69'h0);

      // Flush while FULL with a valid input, then flush while empty.
      step(1, 0, 0, 4'h9, 69'h101);
      step(1, 0, 0, 4'h6, 69'h102);
      step(1, 1, 0, 4'hF, 69'h103);
      repeat (2) step(0, 0, 0, 4'h0, 69'h0);
      step(0, 1, 0, 4'h0, 69'h0);
      repeat (2) step(0, 0, 1, 4'h0, 69'h0);

      // Long stall to saturate the 4-bit counter.
      step(1, 0, 0, 4'h7, 69'h55);
      repeat (20) step(0, 0, 0, 4'h0, 69'h0);

      // Replace the output in one cycle (SKID=0 single register).
      step(1, 0, 1, 4'h8, 69'h66);
      repeat (3) step(0, 0, 1, 4'h0, 69'h0);

      // Randomised traffic.
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 9) < 6), 4'($urandom), rnd_data());
      end

      // Asynchronous reset mid-cycle while FULL, with a flush pending.
      step(1, 0, 0, 4'hE, 69'h201);
      step(1, 0, 0, 4'hD, 69'h202);
      step(1, 1, 0, 4'hF, 69'h203);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst_valid", 0, 69'(ov0), 69'd0);
      chk("arst_ctrl", 0, 69'(oc0), 69'd0);
      chk("arst_data", 0, od0, 69'd0);
      chk("arst_stall", 0, 69'(sc0), 69'd0);
      chk("arst_flush", 0, 69'(fc0), 69'd0);
      chk("arst_ready", 0, 69'(ir0), 69'd1);
      chk("arst_ready_s0", 1, 69'(ir1), 69'(out_ready || 1'b1 && !ov1));
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(($urandom_range(0, 1) == 1), 1'b0, ($urandom_range(0, 1) == 1),
              4'($urandom), rnd_data());
      end
      repeat (3) step(0, 0, 1, 4'h0, 69'h0);
      @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
